video_fb_writer: RTL

VIDEO_FB_WRITER -- requirements
Module: video_fb_writer

---
 rtl/video_fb_writer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/video_fb_writer.sv
// Pixel-stream to Avalon-MM framebuffer writer with a small in-order write queue.
// Optional double buffering is compiled in with `define FB_DOUBLE_BUFFER_EN.
module video_fb_writer #(
    parameter int RGB_SIZE   = 12,
    parameter int AVN_AW     = 20,
    parameter int AVN_DW     = 16,
    parameter int H_DISPLAY  = 640,
    parameter int V_DISPLAY  = 480,
    parameter int HC_W       = 10,
    parameter int VC_W       = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [HC_W-1:0]     src_hc,
    input  logic [VC_W-1:0]     src_vc,
    input  logic [RGB_SIZE-1:0] src_rgb,
    input  logic                src_vld,
    output logic                src_rdy,
    output logic [AVN_AW-1:0]   avn_address,
    output logic                avn_write,
    output logic [AVN_DW-1:0]   avn_writedata,
    output logic [AVN_DW/8-1:0] avn_byteenable,
    input  logic                avn_waitrequest,
    output logic                frame_done,
    output logic                busy,
    input  logic                swap_req,
    output logic                front_sel
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [AVN_AW-1:0] FRAME_WORDS = AVN_AW'(H_DISPLAY * V_DISPLAY);
    localparam logic [HC_W:0]     H_LIM       = (HC_W + 1)'(H_DISPLAY);
    localparam logic [VC_W:0]     V_LIM       = (VC_W + 1)'(V_DISPLAY);
    localparam logic [HC_W-1:0]   H_LAST      = HC_W'(H_DISPLAY - 1);
    localparam logic [VC_W-1:0]   V_LAST      = VC_W'(V_DISPLAY - 1);

    // Queue storage: one register set per entry, head read combinationally.
    logic [AVN_AW-1:0]     addr_mem [FIFO_DEPTH];
    logic [AVN_DW-1:0]     data_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_mem;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;

    logic              in_range;
    logic              accept;
    logic              push;
    logic              pop;
    logic [AVN_AW-1:0] base;
    logic [AVN_AW-1:0] row_off;
    logic [AVN_AW-1:0] pix_addr;
    logic [AVN_DW-1:0] pix_data;
    logic              pix_last;

    assign in_range = ({1'b0, src_hc} < H_LIM) && ({1'b0, src_vc} < V_LIM);
    assign src_rdy  = ~count_reg[PTR_W];
    assign accept   = src_vld & src_rdy;
    assign push     = accept & in_range;
    assign busy     = (count_reg != '0);
    assign pop      = busy & ~avn_waitrequest;

    assign row_off  = AVN_AW'(src_vc) * AVN_AW'(H_DISPLAY);
    assign pix_addr = base + row_off + AVN_AW'(src_hc);
    assign pix_data = AVN_DW'(src_rgb);
    assign pix_last = (src_hc == H_LAST) && (src_vc == V_LAST);

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Pointers are PTR_W wide, so increments wrap modulo FIFO_DEPTH.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge sys_clk) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    addr_mem[gi] <= pix_addr;
                    data_mem[gi] <= pix_data;
                    last_mem[gi] <= pix_last;
                end
            end
        end
    endgenerate

    // Gating by busy keeps the bus quiet (and zero) whenever the queue is empty.
    assign avn_write      = busy;
    assign avn_address    = busy ? addr_mem[rd_ptr_reg] : '0;
    assign avn_writedata  = busy ? data_mem[rd_ptr_reg] : '0;
    assign avn_byteenable = '1;
    assign frame_done     = pop & last_mem[rd_ptr_reg];

`ifdef FB_DOUBLE_BUFFER_EN
    logic front_sel_reg;
    logic swap_pending_reg;

    // A swap request coincident with frame_done takes effect on that frame.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            front_sel_reg    <= 1'b0;
            swap_pending_reg <= 1'b0;
        end else if (frame_done && (swap_pending_reg || swap_req)) begin
            front_sel_reg    <= ~front_sel_reg;
            swap_pending_reg <= 1'b0;
        end else if (swap_req) begin
            swap_pending_reg <= 1'b1;
        end
    end

    assign front_sel = front_sel_reg;
    assign base      = front_sel_reg ? '0 : FRAME_WORDS;
`else
    logic unused_swap_req;

    assign unused_swap_req = swap_req;
    assign front_sel       = 1'b0;
    assign base            = '0;
`endif

endmodule
